// File: rtl/mem_arb_pkg.sv
// Shared types and bounds for the two-master memory port arbiter.
package mem_arb_pkg;

    typedef enum logic {
        StIdle,
        StWait
    } arb_state_e;

    typedef logic master_id_t;

    localparam int unsigned MemLatMax = 4;
    localparam int unsigned CntW      = 3;

    typedef logic [CntW-1:0] lat_cnt_t;

endpackage

// File: rtl/rr_arb2.sv
// Combinational two-way round-robin pick; on conflict the master that did not win last goes.
module rr_arb2
    import mem_arb_pkg::*;
(
    input  logic [1:0]  req_i,
    input  master_id_t  last_i,
    output logic [1:0]  win_o,
    output master_id_t  win_id_o
);

    always_comb begin
        win_o    = 2'b00;
        win_id_o = 1'b0;
        case (req_i)
            2'b01: begin
                win_o    = 2'b01;
                win_id_o = 1'b0;
            end
            2'b10: begin
                win_o    = 2'b10;
                win_id_o = 1'b1;
            end
            2'b11: begin
                if (last_i) begin
                    win_o    = 2'b01;
                    win_id_o = 1'b0;
                end else begin
                    win_o    = 2'b10;
                    win_id_o = 1'b1;
                end
            end
            default: begin
                win_o    = 2'b00;
                win_id_o = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one synchronous memory port between two masters; one transaction in flight,
// round-robin on conflict, read data routed back to the owner after MEM_LAT cycles.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned ADDR_W  = 32,
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned MEM_LAT = 1
) (
    input  logic              clk,
    input  logic              resetn,

    input  logic              m0_req,
    input  logic              m0_we,
    input  logic [ADDR_W-1:0] m0_addr,
    input  logic [DATA_W-1:0] m0_wdata,
    output logic              m0_gnt,
    output logic              m0_rvalid,
    output logic [DATA_W-1:0] m0_rdata,

    input  logic              m1_req,
    input  logic              m1_we,
    input  logic [ADDR_W-1:0] m1_addr,
    input  logic [DATA_W-1:0] m1_wdata,
    output logic              m1_gnt,
    output logic              m1_rvalid,
    output logic [DATA_W-1:0] m1_rdata,

    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_we,
    input  logic [DATA_W-1:0] mem_rdata
);

    if (MEM_LAT < 1 || MEM_LAT > MemLatMax) begin : g_bad_lat
        $error("mem_port_arbiter: MEM_LAT out of range 1..4");
    end

    localparam lat_cnt_t LatLoad = lat_cnt_t'(MEM_LAT);

    arb_state_e        state_q, state_d;
    lat_cnt_t          cnt_q, cnt_d;
    master_id_t        owner_q, owner_d;
    master_id_t        last_q, last_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;

    logic [1:0]        win;
    master_id_t        win_id;
    logic [1:0]        gnt;
    logic [1:0]        rvalid;
    logic              sel_we;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_wdata;

    rr_arb2 u_rr_arb2 (
        .req_i    ({m1_req, m0_req}),
        .last_i   (last_q),
        .win_o    (win),
        .win_id_o (win_id)
    );

    assign sel_we    = win_id ? m1_we    : m0_we;
    assign sel_addr  = win_id ? m1_addr  : m0_addr;
    assign sel_wdata = win_id ? m1_wdata : m0_wdata;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        owner_d = owner_q;
        last_d  = last_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        gnt     = 2'b00;
        rvalid  = 2'b00;
        mem_we  = 1'b0;
        // Nothing is granted or returned while reset is held, so a read in flight just vanishes.
        if (resetn) begin
            unique case (state_q)
                StIdle: begin
                    if (|win) begin
                        gnt     = win;
                        mem_we  = sel_we;
                        addr_d  = sel_addr;
                        wdata_d = sel_wdata;
                        last_d  = win_id;
                        if (!sel_we) begin
                            state_d = StWait;
                            owner_d = win_id;
                            cnt_d   = LatLoad;
                        end
                    end
                end
                StWait: begin
                    cnt_d = cnt_q - lat_cnt_t'(1);
                    if (cnt_q == lat_cnt_t'(1)) begin
                        rvalid[owner_q] = 1'b1;
                        state_d         = StIdle;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            owner_q <= 1'b0;
            last_q  <= 1'b1;
            addr_q  <= '0;
            wdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            owner_q <= owner_d;
            last_q  <= last_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
        end
    end

    // addr_d/wdata_d equal the held values except in an issue cycle.
    assign mem_addr  = addr_d;
    assign mem_wdata = wdata_d;

    assign m0_gnt    = gnt[0];
    assign m1_gnt    = gnt[1];
    assign m0_rvalid = rvalid[0];
    assign m1_rvalid = rvalid[1];
    assign m0_rdata  = rvalid[0] ? mem_rdata : '0;
    assign m1_rdata  = rvalid[1] ? mem_rdata : '0;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench: three arbiters with MEM_LAT = 1, 2, 3 each behind a small read-latch memory.
module tb_mem_port_arbiter;

    logic        clk;
    logic        resetn;

    logic        m0_req[3], m0_we[3], m1_req[3], m1_we[3];
    logic [31:0] m0_addr[3], m0_wdata[3], m1_addr[3], m1_wdata[3];
    logic        m0_gnt[3], m0_rvalid[3], m1_gnt[3], m1_rvalid[3];
    logic [31:0] m0_rdata[3], m1_rdata[3];
    logic [31:0] mem_addr[3], mem_wdata[3], mem_rdata[3];
    logic        mem_we[3];

    int passed;
    int total;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    for (genvar k = 0; k < 3; k++) begin : g_dut
        logic [31:0] raddr_q;

        mem_port_arbiter #(
            .ADDR_W  (32),
            .DATA_W  (32),
            .MEM_LAT (k + 1)
        ) u_dut (
            .clk       (clk),
            .resetn    (resetn),
            .m0_req    (m0_req[k]),
            .m0_we     (m0_we[k]),
            .m0_addr   (m0_addr[k]),
            .m0_wdata  (m0_wdata[k]),
            .m0_gnt    (m0_gnt[k]),
            .m0_rvalid (m0_rvalid[k]),
            .m0_rdata  (m0_rdata[k]),
            .m1_req    (m1_req[k]),
            .m1_we     (m1_we[k]),
            .m1_addr   (m1_addr[k]),
            .m1_wdata  (m1_wdata[k]),
            .m1_gnt    (m1_gnt[k]),
            .m1_rvalid (m1_rvalid[k]),
            .m1_rdata  (m1_rdata[k]),
            .mem_addr  (mem_addr[k]),
            .mem_wdata (mem_wdata[k]),
            .mem_we    (mem_we[k]),
            .mem_rdata (mem_rdata[k])
        );

        // Memory captures the read address at issue; data is stable until the next read.
        always_ff @(posedge clk) begin
            if (!mem_we[k] && (m0_gnt[k] || m1_gnt[k])) raddr_q <= mem_addr[k];
        end
        assign mem_rdata[k] = (raddr_q == 32'h100) ? 32'hDEADBEEF : (raddr_q ^ 32'h5A5A_0000);
    end

    task automatic idle_inputs();
        for (int k = 0; k < 3; k++) begin
            m0_req[k] = 1'b0; m0_we[k] = 1'b0; m0_addr[k] = '0; m0_wdata[k] = '0;
            m1_req[k] = 1'b0; m1_we[k] = 1'b0; m1_addr[k] = '0; m1_wdata[k] = '0;
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        resetn = 1'b0;
        next_cycle();
        next_cycle();
        resetn = 1'b1;
        @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            total++;
            if ({m0_gnt[k], m1_gnt[k], m0_rvalid[k], m1_rvalid[k], mem_we[k]} !== 5'b0) begin
                $display("FAIL reset_ctrl[%0d]: got %b want 00000", k,
                         {m0_gnt[k], m1_gnt[k], m0_rvalid[k], m1_rvalid[k], mem_we[k]});
            end else passed++;
            total++;
            if ({mem_addr[k], mem_wdata[k], m0_rdata[k], m1_rdata[k]} !== 128'h0) begin
                $display("FAIL reset_data[%0d]: addr %h wdata %h rd0 %h rd1 %h want all 0", k,
                         mem_addr[k], mem_wdata[k], m0_rdata[k], m1_rdata[k]);
            end else passed++;
        end
        next_cycle();
    endtask

    task automatic test_single_read();
        m0_req[1] = 1'b1; m0_we[1] = 1'b0; m0_addr[1] = 32'h100;
        @(negedge clk);
        total++;
        if (m0_gnt[1] !== 1'b1 || mem_addr[1] !== 32'h100 || mem_we[1] !== 1'b0) begin
            $display("FAIL read_issue: gnt %b addr %h we %b want 1 00000100 0",
                     m0_gnt[1], mem_addr[1], mem_we[1]);
        end else passed++;
        next_cycle();
        m0_req[1] = 1'b0;
        @(negedge clk);
        total++;
        if (m0_rvalid[1] !== 1'b0) $display("FAIL read_early: rvalid %b want 0", m0_rvalid[1]);
        else passed++;
        next_cycle();
        @(negedge clk);
        total++;
        if (m0_rvalid[1] !== 1'b1 || m0_rdata[1] !== 32'hDEADBEEF) begin
            $display("FAIL read_data: rvalid %b rdata %h want 1 deadbeef", m0_rvalid[1], m0_rdata[1]);
        end else passed++;
        total++;
        if (m1_rvalid[1] !== 1'b0 || m1_rdata[1] !== 32'h0) begin
            $display("FAIL read_nonowner: rvalid %b rdata %h want 0 0", m1_rvalid[1], m1_rdata[1]);
        end else passed++;
        next_cycle();
        @(negedge clk);
        total++;
        if (m0_rvalid[1] !== 1'b0) $display("FAIL read_late: rvalid %b want 0", m0_rvalid[1]);
        else passed++;
        next_cycle();
    endtask

    task automatic test_simultaneous_writes();
        m0_req[0] = 1'b1; m0_we[0] = 1'b1; m0_addr[0] = 32'h10; m0_wdata[0] = 32'hA;
        m1_req[0] = 1'b1; m1_we[0] = 1'b1; m1_addr[0] = 32'h20; m1_wdata[0] = 32'hB;
        @(negedge clk);
        total++;
        if (m0_gnt[0] !== 1'b1 || m1_gnt[0] !== 1'b0 || mem_we[0] !== 1'b1 ||
            mem_addr[0] !== 32'h10 || mem_wdata[0] !== 32'hA) begin
            $display("FAIL wr_first: g0 %b g1 %b we %b addr %h wd %h want 1 0 1 10 a",
                     m0_gnt[0], m1_gnt[0], mem_we[0], mem_addr[0], mem_wdata[0]);
        end else passed++;
        next_cycle();
        m0_req[0] = 1'b0;
        @(negedge clk);
        total++;
        if (m1_gnt[0] !== 1'b1 || m0_gnt[0] !== 1'b0 || mem_we[0] !== 1'b1 ||
            mem_addr[0] !== 32'h20 || mem_wdata[0] !== 32'hB) begin
            $display("FAIL wr_second: g0 %b g1 %b we %b addr %h wd %h want 0 1 1 20 b",
                     m0_gnt[0], m1_gnt[0], mem_we[0], mem_addr[0], mem_wdata[0]);
        end else passed++;
        next_cycle();
        m1_req[0] = 1'b0;
        @(negedge clk);
        total++;
        if (mem_we[0] !== 1'b0 || mem_addr[0] !== 32'h20 || mem_wdata[0] !== 32'hB) begin
            $display("FAIL wr_hold: we %b addr %h wd %h want 0 20 b",
                     mem_we[0], mem_addr[0], mem_wdata[0]);
        end else passed++;
        next_cycle();
    endtask

    task automatic test_round_robin();
        int n_gnt = 0;
        int n_rv0 = 0;
        int n_rv1 = 0;
        m0_req[0] = 1'b1; m0_we[0] = 1'b0; m0_addr[0] = 32'h200;
        m1_req[0] = 1'b1; m1_we[0] = 1'b0; m1_addr[0] = 32'h300;
        for (int c = 0; c < 14; c++) begin
            @(negedge clk);
            if (m0_gnt[0] || m1_gnt[0]) begin
                total++;
                if (m1_gnt[0] !== logic'(n_gnt % 2) || m0_gnt[0] === m1_gnt[0]) begin
                    $display("FAIL rr_order[%0d]: g0 %b g1 %b want g1=%0d", n_gnt,
                             m0_gnt[0], m1_gnt[0], n_gnt % 2);
                end else passed++;
                n_gnt++;
            end
            if (m0_rvalid[0]) begin
                n_rv0++;
                total++;
                if (m0_rdata[0] !== 32'h5A5A_0200) begin
                    $display("FAIL rr_data0: got %h want 5a5a0200", m0_rdata[0]);
                end else passed++;
            end
            if (m1_rvalid[0]) begin
                n_rv1++;
                total++;
                if (m1_rdata[0] !== 32'h5A5A_0300) begin
                    $display("FAIL rr_data1: got %h want 5a5a0300", m1_rdata[0]);
                end else passed++;
            end
            next_cycle();
            if (n_gnt == 6) begin
                m0_req[0] = 1'b0;
                m1_req[0] = 1'b0;
            end
        end
        total++;
        if (n_gnt != 6 || n_rv0 != 3 || n_rv1 != 3) begin
            $display("FAIL rr_counts: gnt %0d rv0 %0d rv1 %0d want 6 3 3", n_gnt, n_rv0, n_rv1);
        end else passed++;
    endtask

    task automatic test_req_during_wait();
        m0_req[2] = 1'b1; m0_we[2] = 1'b0; m0_addr[2] = 32'h100;
        @(negedge clk);
        total++;
        if (m0_gnt[2] !== 1'b1) $display("FAIL wait_issue: gnt %b want 1", m0_gnt[2]);
        else passed++;
        next_cycle();
        m0_req[2] = 1'b0;
        m1_req[2] = 1'b1; m1_we[2] = 1'b0; m1_addr[2] = 32'h40;
        for (int c = 1; c <= 3; c++) begin
            @(negedge clk);
            total++;
            if (m1_gnt[2] !== 1'b0 || mem_we[2] !== 1'b0 || m0_rvalid[2] !== (c == 3)) begin
                $display("FAIL wait_cycle[%0d]: g1 %b we %b rv0 %b want 0 0 %0d", c,
                         m1_gnt[2], mem_we[2], m0_rvalid[2], c == 3);
            end else passed++;
            next_cycle();
        end
        @(negedge clk);
        total++;
        if (m1_gnt[2] !== 1'b1 || mem_addr[2] !== 32'h40) begin
            $display("FAIL wait_m1_gnt: gnt %b addr %h want 1 00000040", m1_gnt[2], mem_addr[2]);
        end else passed++;
        next_cycle();
        m1_req[2] = 1'b0;
        next_cycle();
        next_cycle();
        @(negedge clk);
        total++;
        if (m1_rvalid[2] !== 1'b1 || m1_rdata[2] !== 32'h5A5A_0040 || m0_rvalid[2] !== 1'b0) begin
            $display("FAIL wait_m1_data: rv1 %b rd1 %h rv0 %b want 1 5a5a0040 0",
                     m1_rvalid[2], m1_rdata[2], m0_rvalid[2]);
        end else passed++;
        next_cycle();
    endtask

    task automatic test_reset_mid_read();
        m0_req[1] = 1'b1; m0_we[1] = 1'b0; m0_addr[1] = 32'h80;
        @(negedge clk);
        total++;
        if (m0_gnt[1] !== 1'b1) $display("FAIL rst_issue: gnt %b want 1", m0_gnt[1]);
        else passed++;
        next_cycle();
        m0_req[1] = 1'b0;
        resetn = 1'b0;
        @(negedge clk);
        total++;
        if (m0_rvalid[1] !== 1'b0 || m1_rvalid[1] !== 1'b0) begin
            $display("FAIL rst_no_rvalid: rv0 %b rv1 %b want 0 0", m0_rvalid[1], m1_rvalid[1]);
        end else passed++;
        next_cycle();
        @(negedge clk);
        total++;
        if ({m0_gnt[1], m1_gnt[1], m0_rvalid[1], m1_rvalid[1], mem_we[1]} !== 5'b0 ||
            mem_addr[1] !== 32'h0 || mem_wdata[1] !== 32'h0 || m0_rdata[1] !== 32'h0) begin
            $display("FAIL rst_outputs: addr %h wdata %h rd0 %h we %b want 0 0 0 0",
                     mem_addr[1], mem_wdata[1], m0_rdata[1], mem_we[1]);
        end else passed++;
        next_cycle();
        resetn = 1'b1;
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            total++;
            if (m0_rvalid[1] !== 1'b0) $display("FAIL rst_stale[%0d]: rv0 %b want 0", c, m0_rvalid[1]);
            else passed++;
            next_cycle();
        end
        // The previous read left last = m0, so only a reset-restored pointer lets m0 win here.
        m0_req[1] = 1'b1; m0_we[1] = 1'b1; m0_addr[1] = 32'h44; m0_wdata[1] = 32'h1;
        m1_req[1] = 1'b1; m1_we[1] = 1'b1; m1_addr[1] = 32'h48; m1_wdata[1] = 32'h2;
        @(negedge clk);
        total++;
        if (m0_gnt[1] !== 1'b1 || m1_gnt[1] !== 1'b0 || mem_addr[1] !== 32'h44) begin
            $display("FAIL rst_first_conflict: g0 %b g1 %b addr %h want 1 0 00000044",
                     m0_gnt[1], m1_gnt[1], mem_addr[1]);
        end else passed++;
        next_cycle();
        idle_inputs();
        next_cycle();
    endtask

    initial begin
        passed = 0;
        total  = 0;
        resetn = 1'b0;
        idle_inputs();
        test_reset();
        test_single_read();
        test_simultaneous_writes();
        test_round_robin();
        test_req_during_wait();
        test_reset_mid_read();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Two-requester arbiter that shares the single synchronous memory port between the multicycle RISC-V core (requester 0) and a second bus master such as the program loader or a DMA engine (requester 1). It sequences one transaction at a time, grants fairly with round-robin priority, and returns read data to the owning requester after a fixed memory latency. It sits between the masters and the memory model. The core gains a grant/valid handshake in place of its direct address/we wiring.

## Interface
Parameters:
- ADDR_W, 32, address width
- DATA_W, 32, data width
- MEM_LAT, 1, cycles from read issue to valid mem_rdata; legal range 1..4

Ports:
- clk  in  1  clock
- resetn  in  1  synchronous, active-low reset
- mN_req  in  1  request from master N (N = 0, 1); held until mN_gnt
- mN_we  in  1  1 = write, 0 = read; stable while mN_req is high
- mN_addr  in  ADDR_W  byte address; stable while mN_req is high
- mN_wdata  in  DATA_W  write data; stable while mN_req is high
- mN_gnt  out  1  one-cycle pulse: the request is accepted and issued to memory this cycle
- mN_rvalid  out  1  one-cycle pulse: mN_rdata is valid
- mN_rdata  out  DATA_W  read data, valid only with mN_rvalid
- mem_addr  out  ADDR_W  memory address
- mem_wdata  out  DATA_W  memory write data
- mem_we  out  1  memory write strobe
- mem_rdata  in  DATA_W  memory read data

## Operation
- Reset values:
  - all gnt, rvalid and mem_we are 0.
  - mem_addr, mem_wdata and rdata outputs are 0.
  - FSM is IDLE.
  - Priority pointer `last` = 1, so m0 wins the first conflict.
- The FSM has two states, IDLE and WAIT.
- IDLE behaviour:
  - If neither request is high, the FSM stays in IDLE.
  - If exactly one request is high, that master wins.
  - If both are high, the master ≠ `last` wins.
- Issue cycle (in IDLE, with a winner W):
  - mW_gnt = 1.
  - mem_addr and mem_wdata are driven from W.
  - mem_we = mW_we.
  - `last` is set to W.
- Write: completes in the issue cycle, and the FSM stays in IDLE.
- Read: the FSM goes to WAIT. It latches owner = W and loads cnt = MEM_LAT.
- WAIT behaviour:
  - No grants are issued and mem_we = 0.
  - cnt decrements each cycle.
  - When cnt reaches 1, mOwner_rvalid = 1 and mOwner_rdata = mem_rdata in that cycle.
  - The FSM then returns to IDLE.
- When not issuing, mem_addr and mem_wdata hold their last issued values and mem_we = 0.
- The losing requester keeps its request high. It is guaranteed the next grant, which bounds starvation to one transaction.
- The non-owner never sees rvalid, and its rdata stays 0.
- Reset mid-read: the FSM returns to IDLE, no rvalid is produced, and the pending read is discarded.
- Requests asserted during WAIT are evaluated on the first IDLE cycle after it.

## Timing
- Grant is combinational from req in IDLE, so the latency is 0 cycles from req to gnt.
- Read data: rvalid occurs exactly MEM_LAT cycles after the gnt cycle.
- Throughput:
  - Writes: 1 per cycle. Back-to-back writes from both masters alternate each cycle.
  - Reads: 1 per MEM_LAT+1 cycles.
- After rvalid, the FSM is in IDLE on the next cycle and can grant in that same cycle.
- A master may drop req in the cycle after gnt. A req held high after gnt is treated as a new request.

## Structure
- Package mem_arb_pkg holds:
  - the state enum (IDLE, WAIT)
  - a 1-bit master-id type
  - the MEM_LAT legality bound (max 4), which sets the counter width to 3 bits
- Sub-module rr_arb2: a purely combinational 2-way round-robin pick.
  - Inputs: req[1:0] and last.
  - Outputs: one-hot win[1:0] and win_id.
- mem_port_arbiter holds the FSM, the counter, the owner, the `last` register and the output muxing.

## Test plan
- Single read with MEM_LAT=2: m0 reads 0x100 while memory returns 0xDEADBEEF.
  - m0_gnt is high in cycle t.
  - m0_rvalid is high in cycle t+2 with m0_rdata = 0xDEADBEEF.
  - m1_rvalid stays 0.
- Simultaneous writes: m0 writes 0x10←0xA, m1 writes 0x20←0xB, both raised in the same cycle after reset.
  - m0 is granted first (mem_we=1, addr 0x10).
  - m1 is granted in the next cycle (addr 0x20).
- Round-robin under contention: both masters hold read requests for 6 transactions with MEM_LAT=1.
  - Grants alternate 0,1,0,1,0,1.
  - Each master receives exactly 3 rvalid pulses with the matching data.
- Request during WAIT: m1 raises req one cycle after m0's read gnt, with MEM_LAT=3.
  - m1_gnt occurs no earlier than the cycle of m0_rvalid.
  - mem_we stays 0 throughout WAIT.
- Reset mid-read: m0 read granted, then resetn=0 in the following cycle.
  - No rvalid is produced.
  - All outputs are 0 and the FSM is IDLE.
  - After release, the first conflict grants m0.
